// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the WS2812 pixel pipeline: pixel geometry, byte
// slice positions inside a received 24-bit word, the assembler state
// encoding and a helper that splits a raw word into its colour bytes.
// No ports (package).
// -----------------------------------------------------------------------------
package rgb_pkg;

   localparam int BITS_PER_PIXEL = 24;
   localparam int BYTE_W         = 8;

   // Upper bit of each colour byte in the received word (G arrives first).
   localparam int G_HI = 23;
   localparam int R_HI = 15;
   localparam int B_HI = 7;

   localparam logic ST_ACCUM   = 1'b0;
   localparam logic ST_DISCARD = 1'b1;

   typedef enum logic {
      S_ACCUM   = ST_ACCUM,
      S_DISCARD = ST_DISCARD
   } asm_state_t;

   typedef struct packed {
      logic [BYTE_W-1:0] g;
      logic [BYTE_W-1:0] r;
      logic [BYTE_W-1:0] b;
   } pixel_t;

   // Split a word in wire order (G,R,B, MSB first) into its colour bytes.
   function automatic pixel_t split_pixel(input logic [BITS_PER_PIXEL-1:0] word);
      pixel_t p;
      p.g = word[G_HI -: BYTE_W];
      p.r = word[R_HI -: BYTE_W];
      p.b = word[B_HI -: BYTE_W];
      return p;
   endfunction

endpackage

// File: rtl/rgb_pix_hold.sv
// -----------------------------------------------------------------------------
// rgb_pix_hold
// Single-entry output register for a pixel stream with valid/ready handshake.
// A pixel offered on 'load' is captured when the register is empty or is
// being emptied this cycle; otherwise it is dropped and 'overrun' pulses.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         one-cycle request to capture load_pix/load_idx
//   load_pix     pixel to capture
//   load_idx     frame position of that pixel
//   ready        consumer accepts the held pixel when valid && ready
//   valid        held pixel available
//   pix          held pixel
//   idx          frame position of held pixel
//   first        held pixel is the first of its frame (idx == 0)
//   overrun      one-cycle pulse: offered pixel dropped
// -----------------------------------------------------------------------------
module rgb_pix_hold
   import rgb_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  pixel_t           load_pix,
   input  logic [IDX_W-1:0] load_idx,
   input  logic             ready,
   output logic             valid,
   output pixel_t           pix,
   output logic [IDX_W-1:0] idx,
   output logic             first,
   output logic             overrun
);

   // The held entry may only be replaced once the consumer has taken it, so a
   // load against a stalled entry is dropped and reported instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 1'b0;
         pix     <= '0;
         idx     <= '0;
         first   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (valid && !ready) begin
               overrun <= 1'b1;
            end else begin
               valid <= 1'b1;
               pix   <= load_pix;
               idx   <= load_idx;
               first <= (load_idx == '0);
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rgb_pixel_asm.sv
// -----------------------------------------------------------------------------
// rgb_pixel_asm
// Assembles the decoded WS2812 bit stream into 24-bit pixels (G,R,B, MSB
// first), numbers them within the frame and presents them on a valid/ready
// interface. Frame boundaries come from the stream_reset level.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bit_in         decoded bit value
//   bit_strobe     one-cycle pulse, bit_in valid
//   stream_reset   high while the line has been idle for the reset time
//   pix_valid      pixel available
//   pix_ready      consumer accepts when pix_valid && pix_ready
//   pix_g/r/b      colour bytes of the held pixel
//   pix_idx        0-based position of the pixel in its frame
//   frame_start    pix_valid for the first pixel of a frame
//   frame_done     pulse on stream_reset rise when the frame had pixels
//   frag_err       pulse on stream_reset rise with a partial pixel pending
//   overrun        pulse when a completed pixel had to be dropped
// -----------------------------------------------------------------------------
module rgb_pixel_asm
   import rgb_pkg::*;
#(
   parameter int MAX_PIXELS = 256,
   parameter int IDX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_strobe,
   input  logic             stream_reset,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [7:0]       pix_g,
   output logic [7:0]       pix_r,
   output logic [7:0]       pix_b,
   output logic [IDX_W-1:0] pix_idx,
   output logic             frame_start,
   output logic             frame_done,
   output logic             frag_err,
   output logic             overrun
);

   localparam logic [4:0]     LAST_BIT = 5'(BITS_PER_PIXEL - 1);
   // The pixel counter is one bit wider than the index so it can hold
   // MAX_PIXELS itself; the last in-frame pixel has count LAST_PIX.
   localparam logic [IDX_W:0] LAST_PIX = (IDX_W + 1)'(MAX_PIXELS - 1);

   asm_state_t                state;
   logic [BITS_PER_PIXEL-1:0] sr;
   logic [4:0]                bit_cnt;
   logic [IDX_W:0]            pix_cnt;
   logic                      sreset_q;

   logic                      sreset_rise;
   logic                      take_bit;
   logic                      complete;
   logic [BITS_PER_PIXEL-1:0] next_word;

   pixel_t                    hold_pix;
   logic                      hold_first;

   // A frame boundary takes priority over a bit arriving in the same cycle.
   assign sreset_rise = stream_reset && !sreset_q;
   assign take_bit    = bit_strobe && !sreset_rise && (state == S_ACCUM);
   assign next_word   = {sr[BITS_PER_PIXEL-2:0], bit_in};
   assign complete    = take_bit && (bit_cnt == LAST_BIT);

   // Bit accumulation, frame counting and the ACCUM/DISCARD machine.
   // The completed word is handed to the output register straight from
   // next_word so the pixel is visible the cycle after its last strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_ACCUM;
         sr         <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         sreset_q   <= 1'b0;
         frag_err   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sreset_q   <= stream_reset;
         frag_err   <= sreset_rise && (bit_cnt != '0);
         frame_done <= sreset_rise && (pix_cnt != '0);
         if (sreset_rise) begin
            state   <= S_ACCUM;
            sr      <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
         end else if (take_bit) begin
            sr <= next_word;
            if (complete) begin
               bit_cnt <= '0;
               pix_cnt <= pix_cnt + 1'b1;
               if (pix_cnt == LAST_PIX) begin
                  state <= S_DISCARD;
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   rgb_pix_hold #(
      .IDX_W (IDX_W)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (complete),
      .load_pix (split_pixel(next_word)),
      .load_idx (pix_cnt[IDX_W-1:0]),
      .ready    (pix_ready),
      .valid    (pix_valid),
      .pix      (hold_pix),
      .idx      (pix_idx),
      .first    (hold_first),
      .overrun  (overrun)
   );

   assign pix_g       = hold_pix.g;
   assign pix_r       = hold_pix.r;
   assign pix_b       = hold_pix.b;
   // Only flag a frame start while the pixel is actually on offer.
   assign frame_start = pix_valid && hold_first;

endmodule

// File: tb/tb_rgb_pixel_asm.sv
// -----------------------------------------------------------------------------
// tb_rgb_pixel_asm
// Drives a default build and a two-pixel build of rgb_pixel_asm with the same
// stimulus and compares both against a behavioural model every cycle, plus
// explicit expected values for table vectors and corner-case sequences.
// -----------------------------------------------------------------------------
module tb_rgb_pixel_asm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_strobe = 1'b0;
   logic       stream_reset = 1'b0;
   logic       pix_ready = 1'b0;

   logic       v0, fs0, fd0, fe0, ov0;
   logic [7:0] g0, r0, b0, i0;
   logic       v1, fs1, fd1, fe1, ov1;
   logic [7:0] g1, r1, b1, i1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rgb_pixel_asm dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
      .stream_reset(stream_reset), .pix_valid(v0), .pix_ready(pix_ready),
      .pix_g(g0), .pix_r(r0), .pix_b(b0), .pix_idx(i0), .frame_start(fs0),
      .frame_done(fd0), .frag_err(fe0), .overrun(ov0)
   );

   rgb_pixel_asm #(.MAX_PIXELS(2), .IDX_W(8)) dut2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
      .stream_reset(stream_reset), .pix_valid(v1), .pix_ready(pix_ready),
      .pix_g(g1), .pix_r(r1), .pix_b(b1), .pix_idx(i1), .frame_start(fs1),
      .frame_done(fd1), .frag_err(fe1), .overrun(ov1)
   );

   // Behavioural model, one slot per build.
   int          m_max[2] = '{256, 2};
   int          m_nbits[2];
   logic [23:0] m_word[2];
   int          m_pcnt[2];
   logic        m_v[2];
   logic [23:0] m_pix[2];
   int          m_idx[2];
   logic        m_ovr[2], m_frag[2], m_done[2];
   logic        m_prev_sr;

   typedef struct {
      logic [23:0] word;
      logic [7:0]  g, r, b;
      logic [7:0]  idx;
      logic        fs;
   } vec_t;

   vec_t table_v[5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         m_nbits[m] = 0; m_word[m] = '0; m_pcnt[m] = 0; m_v[m] = 1'b0;
         m_pix[m] = '0; m_idx[m] = 0; m_ovr[m] = 1'b0; m_frag[m] = 1'b0; m_done[m] = 1'b0;
      end
      m_prev_sr = 1'b0;
   endtask

   task automatic modelStep(input logic s, input logic b, input logic sr, input logic rdy);
      logic rise;
      rise = sr && !m_prev_sr;
      for (int m = 0; m < 2; m++) begin
         logic done_pix;
         int   new_idx;
         done_pix = 1'b0;
         new_idx  = 0;
         m_frag[m] = rise && (m_nbits[m] != 0);
         m_done[m] = rise && (m_pcnt[m] != 0);
         m_ovr[m]  = 1'b0;
         if (!rise && s && (m_pcnt[m] < m_max[m])) begin
            m_word[m] = 24'((m_word[m] * 2) + b);
            m_nbits[m]++;
            if (m_nbits[m] == 24) begin
               m_nbits[m] = 0;
               done_pix   = 1'b1;
               new_idx    = m_pcnt[m];
               m_pcnt[m]++;
            end
         end
         if (done_pix) begin
            if (m_v[m] && !rdy) m_ovr[m] = 1'b1;
            else begin
               m_v[m] = 1'b1; m_pix[m] = m_word[m]; m_idx[m] = new_idx;
            end
         end else if (m_v[m] && rdy) begin
            m_v[m] = 1'b0;
         end
         if (rise) begin
            m_nbits[m] = 0; m_word[m] = '0; m_pcnt[m] = 0;
         end
      end
      m_prev_sr = sr;
   endtask

   task automatic compareOne(input int m, input logic v, input logic [7:0] g, input logic [7:0] r,
                             input logic [7:0] b, input logic [7:0] idx, input logic fs,
                             input logic ov, input logic fe, input logic fd);
      checkOutput($sformatf("m%0d.valid", m), 32'(v), 32'(m_v[m]));
      checkOutput($sformatf("m%0d.rgb", m), {8'h0, g, r, b}, {8'h0, m_pix[m]});
      checkOutput($sformatf("m%0d.idx", m), 32'(idx), 32'(m_idx[m]));
      checkOutput($sformatf("m%0d.frame_start", m), 32'(fs), 32'(m_v[m] && m_idx[m] == 0));
      checkOutput($sformatf("m%0d.overrun", m), 32'(ov), 32'(m_ovr[m]));
      checkOutput($sformatf("m%0d.frag_err", m), 32'(fe), 32'(m_frag[m]));
      checkOutput($sformatf("m%0d.frame_done", m), 32'(fd), 32'(m_done[m]));
   endtask

   // One clock: drive inputs after a falling edge, advance the model, then
   // compare both builds at the next falling edge.
   task automatic applyStimulus(input logic s, input logic b, input logic sr, input logic rdy);
      bit_strobe = s; bit_in = b; stream_reset = sr; pix_ready = rdy;
      modelStep(s, b, sr, rdy);
      @(negedge clk);
      compareOne(0, v0, g0, r0, b0, i0, fs0, ov0, fe0, fd0);
      compareOne(1, v1, g1, r1, b1, i1, fs1, ov1, fe1, fd1);
   endtask

   task automatic sendPixel(input logic [23:0] w, input logic rdy);
      for (int i = 23; i >= 0; i--) applyStimulus(1'b1, w[i], 1'b0, rdy);
   endtask

   // Raise rst for one cycle; outputs must clear without waiting for a clock.
   task automatic doReset();
      bit_strobe = 1'b0; bit_in = 1'b0; stream_reset = 1'b0; pix_ready = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst.valid", 32'(v0), 32'h0);
      checkOutput("rst.rgb", {8'h0, g0, r0, b0}, 32'h0);
      checkOutput("rst.idx", 32'(i0), 32'h0);
      checkOutput("rst.pulses", {29'h0, ov0, fe0, fd0}, 32'h0);
      checkOutput("rst.valid2", 32'(v1), 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int sr_left;
      logic s, sr;
      modelReset();
      table_v[0] = '{24'h123456, 8'h12, 8'h34, 8'h56, 8'd0, 1'b1};
      table_v[1] = '{24'hFF0000, 8'hFF, 8'h00, 8'h00, 8'd1, 1'b0};
      table_v[2] = '{24'h00FF00, 8'h00, 8'hFF, 8'h00, 8'd2, 1'b0};
      table_v[3] = '{24'h0000FF, 8'h00, 8'h00, 8'hFF, 8'd3, 1'b0};
      table_v[4] = '{24'hA5C381, 8'hA5, 8'hC3, 8'h81, 8'd4, 1'b0};

      @(negedge clk);
      @(negedge clk);
      doReset();

      // Table vectors: each pixel delivered, then accepted.
      for (int k = 0; k < 5; k++) begin
         sendPixel(table_v[k].word, 1'b0);
         checkOutput($sformatf("tab%0d.valid", k), 32'(v0), 32'h1);
         checkOutput($sformatf("tab%0d.rgb", k), {8'h0, g0, r0, b0},
                     {8'h0, table_v[k].g, table_v[k].r, table_v[k].b});
         checkOutput($sformatf("tab%0d.idx", k), 32'(i0), 32'(table_v[k].idx));
         checkOutput($sformatf("tab%0d.fs", k), 32'(fs0), 32'(table_v[k].fs));
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("tab%0d.drop", k), 32'(v0), 32'h0);
      end

      // Overrun: second pixel completes against a stalled first one.
      doReset();
      sendPixel(24'hFF0000, 1'b0);
      sendPixel(24'h00FF00, 1'b0);
      checkOutput("ovr.pulse", 32'(ov0), 32'h1);
      checkOutput("ovr.held_g", 32'(g0), 32'hFF);
      checkOutput("ovr.held_idx", 32'(i0), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr.once", 32'(ov0), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: completion in the acceptance cycle; count is now 2.
      sendPixel(24'h111111, 1'b0);
      checkOutput("b2b.first_idx", 32'(i0), 32'h2);
      for (int i = 23; i > 0; i--) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("b2b.valid", 32'(v0), 32'h1);
      checkOutput("b2b.idx", 32'(i0), 32'h3);
      checkOutput("b2b.rgb", {8'h0, g0, r0, b0}, 32'h000001);
      checkOutput("b2b.no_ovr", 32'(ov0), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Fragment: 10 bits then stream reset in a fresh frame.
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("frag.err", 32'(fe0), 32'h1);
      checkOutput("frag.done", 32'(fd0), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("frag.once", 32'(fe0), 32'h0);
      sendPixel(24'h0F0F0F, 1'b0);
      checkOutput("frag.next_idx", 32'(i0), 32'h0);
      checkOutput("frag.next_fs", 32'(fs0), 32'h1);
      checkOutput("frag.next_g", 32'(g0), 32'h0F);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Two-pixel build: third pixel discarded until stream reset.
      doReset();
      sendPixel(24'h010203, 1'b1);
      checkOutput("max.p0_idx", {31'h0, v1} + 32'(i1), 32'h1);
      sendPixel(24'h040506, 1'b1);
      checkOutput("max.p1_valid", 32'(v1), 32'h1);
      checkOutput("max.p1_idx", 32'(i1), 32'h1);
      sendPixel(24'h070809, 1'b1);
      checkOutput("max.p2_valid", 32'(v1), 32'h0);
      checkOutput("max.p2_ovr", 32'(ov1), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("max.done", 32'(fd1), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      sendPixel(24'h0A0B0C, 1'b0);
      checkOutput("max.again_valid", 32'(v1), 32'h1);
      checkOutput("max.again_idx", 32'(i1), 32'h0);
      checkOutput("max.again_b", 32'(b1), 32'h0C);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Async reset with a held pixel and 12 bits pending.
      sendPixel(24'h445566, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      doReset();
      sendPixel(24'hA5C3E1, 1'b0);
      checkOutput("arst.valid", 32'(v0), 32'h1);
      checkOutput("arst.rgb", {8'h0, g0, r0, b0}, 32'hA5C3E1);
      checkOutput("arst.idx", 32'(i0), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic with occasional stream reset windows.
      sr_left = 0;
      for (int c = 0; c < 5000; c++) begin
         if (sr_left > 0) begin
            sr = 1'b1;
            sr_left--;
         end else begin
            sr = 1'b0;
            if ($urandom_range(0, 299) == 0) sr_left = $urandom_range(3, 15);
         end
         s = ($urandom_range(0, 9) < 6);
         applyStimulus(s, 1'($urandom_range(0, 1)), sr, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rgb_pixel_asm.md
Name: rgb_pixel_asm

Overview:
- Downstream neighbour of rgb_sinp. Consumes its decoded serial bit stream (out/strobe/stream_reset) and assembles 24-bit WS2812-order pixels (G, R, B bytes, MSB first).
- Presents each pixel with an index on a valid/ready interface for the RGB-to-RGBW conversion stage.
- Tracks frame boundaries and flags fragments and overruns.

Parameters:
- MAX_PIXELS, 256, number of pixels accepted per frame; later bits are discarded until stream reset.
- IDX_W, 8, width of pixel index; must satisfy 2**IDX_W >= MAX_PIXELS.

Ports:
- clk  in  1  system clock (same domain as rgb_sinp).
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  decoded bit value (rgb_sinp out).
- bit_strobe  in  1  one-cycle pulse; bit_in valid this cycle.
- stream_reset  in  1  level from rgb_sinp; high while line is idle ≥ reset time.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel when pix_valid && pix_ready.
- pix_g  out  8  green byte (first received).
- pix_r  out  8  red byte.
- pix_b  out  8  blue byte (last received).
- pix_idx  out  IDX_W  position of pixel in frame, 0-based.
- frame_start  out  1  high with pix_valid when pix_idx==0.
- frame_done  out  1  one-cycle pulse on stream_reset rising edge if ≥1 pixel completed in the frame.
- frag_err  out  1  one-cycle pulse: stream_reset rising edge with 1..23 bits pending.
- overrun  out  1  one-cycle pulse: pixel completed while output register still full and not being accepted.

Behaviour:
- Reset values: all outputs 0; shift register 0; bit count 0; pixel count 0; state ACCUM; stream_reset edge register 0.
- State machine with two states:
  - ACCUM: collecting bits.
  - DISCARD: MAX_PIXELS pixels already completed; strobes ignored.
- Leaving DISCARD: only a stream_reset rising edge returns the machine to ACCUM.
- Frame start: reset counts as the start of a frame; no stream_reset is needed before the first bit.
- Bit accumulation:
  - On bit_strobe in ACCUM, shift bit_in into bit 0 of a 24-bit register and increment a 5-bit count (0..23).
  - On the 24th strobe, the count wraps to 0 and the pixel completes.
- Pixel completion: on the next edge, the output register loads {g,r,b} = {sr[23:16], sr[15:8], sr[7:0]} and pix_idx = pixel count. pix_valid rises 1 cycle after the 24th strobe.
- Pixel count: increments per completed pixel, whether the pixel is delivered or dropped. Reaching MAX_PIXELS → state DISCARD.
- Handshake:
  - pix_valid, pix_g/r/b, pix_idx and frame_start are held stable until pix_valid && pix_ready.
  - On acceptance with no new pixel completing, pix_valid drops the next cycle.
  - Completion in the same cycle as acceptance → new pixel loads, pix_valid stays 1 (back-to-back).
  - Completion while pix_valid && !pix_ready → new pixel dropped, held pixel unchanged, overrun pulses for 1 cycle; pixel count still increments.
- Stream reset:
  - Detect the rising edge with a registered copy; act in the edge cycle.
  - Clears bit count, shift register and pixel count; state → ACCUM.
  - frag_err pulses if bit count ≠ 0; frame_done pulses if pixel count ≠ 0 (counts before clear).
  - A held pixel on the output is not disturbed.
- Strobes while stream_reset is high: shifted normally.
- Simultaneous bit_strobe and stream_reset rising edge: reset wins, bit discarded.
- Async rst mid-pixel or mid-handshake: immediate return to reset values; held pixel lost.

Decomposition:
- Shared package rgb_pkg:
  - Constants BITS_PER_PIXEL=24 and BYTE_W=8.
  - State encoding localparams ST_ACCUM and ST_DISCARD.
  - Byte slice offsets G_HI=23, R_HI=15, B_HI=7.
- One natural sub-module: rgb_pix_hold, the single-entry output register with the valid/ready/overrun logic, reusable by the RGBW stage.

Test Plan:
- Reset, then strobe 24 bits of 0x12_34_56 MSB first → pix_valid 1 cycle after last strobe; g=0x12, r=0x34, b=0x56, idx=0, frame_start=1; pix_ready=1 → pix_valid low next cycle.
- Two pixels 0xFF0000 and 0x00FF00, pix_ready held 0 until after the second completes → first pixel held (g=0xFF), overrun pulses once at second completion, idx stays 0; pixel count reaches 2.
- Completion cycle coincides with pix_ready=1 on a held pixel → new pixel (idx=1) loads with no pix_valid gap; no overrun.
- 10 strobes, then stream_reset raised → frag_err one pulse, frame_done 0; next 24 bits yield idx=0, frame_start=1.
- MAX_PIXELS=2 build: send 3 pixels, then stream_reset, then 1 pixel → idx 0,1 delivered, third pixel ignored (no pix_valid, no overrun); frame_done pulses; next pixel idx=0.
- Assert rst for 1 cycle with 12 bits pending and pix_valid=1 → all outputs 0 immediately; subsequent 24 bits form a clean pixel with idx=0.
